// File: rtl/dmem_arbiter_if.sv
// Request/response port and memory-side bus bundles for dmem_arbiter.
// Each requester owns one dmem_port_if; the memory side is dmem_mem_if.
interface dmem_port_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              rsp_valid;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid
    );
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W = 64
);
    logic              write;
    logic              read;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic [63:0]       rdata;

    modport master (
        output write, read, size, addr, wdata,
        input  rdata
    );

    modport slave (
        input  write, read, size, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin front end for the byte-addressed data memory:
// grants one request, checks alignment/range, strobes the memory, returns a response pulse.
module dmem_arbiter #(
    parameter int MEM_BYTES = 88,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    dmem_port_if.slave        a_port,
    dmem_port_if.slave        b_port,
    dmem_mem_if.master        mem,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] nb;
        case (size)
            2'b00:   nb = 4'd4;
            2'b01:   nb = 4'd2;
            2'b10:   nb = 4'd1;
            2'b11:   nb = 4'd8;
            default: nb = 4'd1;
        endcase
        return nb;
    endfunction

    // Range test runs one bit wider than the address so a top-of-space access cannot wrap.
    function automatic logic access_err(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
        logic [2:0]      mask;
        logic [ADDR_W:0] end_addr;
        case (size)
            2'b00:   mask = 3'b011;
            2'b01:   mask = 3'b001;
            2'b10:   mask = 3'b000;
            2'b11:   mask = 3'b111;
            default: mask = 3'b000;
        endcase
        end_addr = {1'b0, addr} + {{(ADDR_W-3){1'b0}}, size_bytes(size)};
        return ((addr[2:0] & mask) != 3'd0) || (end_addr > MEM_LIMIT);
    endfunction

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1 = B was granted last
    logic              port_q, port_d;               // 1 = request belongs to B
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [63:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              a_rsp_valid_q, a_rsp_valid_d;
    logic              b_rsp_valid_q, b_rsp_valid_d;
    logic              grant_s, grant_b_s;
    logic              a_ready_s, b_ready_s;

    // Arbitration, request latch, strobe sequencing and response formation.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        port_d        = port_q;
        write_d       = write_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        a_rsp_valid_d = 1'b0;
        b_rsp_valid_d = 1'b0;
        grant_s       = 1'b0;
        grant_b_s     = 1'b0;
        a_ready_s     = 1'b0;
        b_ready_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_port.req_valid && b_port.req_valid) begin
                    grant_s   = 1'b1;
                    grant_b_s = ~last_grant_q;
                end else if (a_port.req_valid) begin
                    grant_s   = 1'b1;
                    grant_b_s = 1'b0;
                end else if (b_port.req_valid) begin
                    grant_s   = 1'b1;
                    grant_b_s = 1'b1;
                end else begin
                    grant_s   = 1'b0;
                    grant_b_s = 1'b0;
                end

                if (grant_s) begin
                    a_ready_s    = ~grant_b_s;
                    b_ready_s    = grant_b_s;
                    port_d       = grant_b_s;
                    last_grant_d = grant_b_s;
                    write_d      = grant_b_s ? b_port.req_write : a_port.req_write;
                    size_d       = grant_b_s ? b_port.req_size  : a_port.req_size;
                    addr_d       = grant_b_s ? b_port.req_addr  : a_port.req_addr;
                    wdata_d      = grant_b_s ? b_port.req_wdata : a_port.req_wdata;
                    err_d        = access_err(addr_d, size_d);
                    mem_read_d   = ~err_d & ~write_d;
                    mem_write_d  = ~err_d & write_d;
                    state_d      = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_rdata_d   = (~write_q && ~err_q) ? mem.rdata : 64'd0;
                rsp_err_d     = err_q;
                a_rsp_valid_d = ~port_q;
                b_rsp_valid_d = port_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset also kills any in-flight strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            port_q        <= 1'b0;
            write_q       <= 1'b0;
            size_q        <= 2'b00;
            addr_q        <= {ADDR_W{1'b0}};
            wdata_q       <= 64'd0;
            err_q         <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            rsp_rdata_q   <= 64'd0;
            rsp_err_q     <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            port_q        <= port_d;
            write_q       <= write_d;
            size_q        <= size_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
        end
    end

    assign a_port.req_ready = a_ready_s;
    assign b_port.req_ready = b_ready_s;
    assign a_port.rsp_valid = a_rsp_valid_q;
    assign b_port.rsp_valid = b_rsp_valid_q;
    assign mem.read         = mem_read_q;
    assign mem.write        = mem_write_q;
    assign mem.size         = size_q;
    assign mem.addr         = addr_q;
    assign mem.wdata        = wdata_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_err          = rsp_err_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter: a transaction-level model predicts
// grants, strobes and responses from the arbitration rules; a byte-array memory serves the DUT.
module tb_dmem_arbiter;
    localparam int MEM_BYTES = 88;
    localparam int ADDR_W    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    dmem_port_if #(.ADDR_W(ADDR_W)) a_if ();
    dmem_port_if #(.ADDR_W(ADDR_W)) b_if ();
    dmem_mem_if  #(.ADDR_W(ADDR_W)) m_if ();

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_port    (a_if),
        .b_port    (b_if),
        .mem       (m_if),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    endtask

    function automatic int nbytes(input logic [1:0] size);
        case (size)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        logic [63:0] w1;
        w1 = 64'h1122334455667788;
        if (i >= 8 && i < 16) return w1[8*(i-8) +: 8];
        return 8'(i * 37 + 5);
    endfunction

    // Memory served to the DUT: registered read, little-endian byte lanes, zero-filled.
    logic [7:0]  mem_arr [0:MEM_BYTES-1];
    logic [63:0] mem_v;
    logic        load_mem = 1'b0;
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_arr[i] <= init_byte(i);
        end else begin
            if (m_if.write) begin
                for (int i = 0; i < nbytes(m_if.size); i++)
                    if (m_if.addr + 64'(i) < 64'(MEM_BYTES))
                        mem_arr[int'(m_if.addr) + i] <= m_if.wdata[8*i +: 8];
            end
            if (m_if.read) begin
                mem_v = 64'd0;
                for (int i = 0; i < nbytes(m_if.size); i++)
                    if (m_if.addr + 64'(i) < 64'(MEM_BYTES))
                        mem_v[8*i +: 8] = mem_arr[int'(m_if.addr) + i];
                m_if.rdata <= mem_v;
            end
        end
    end

    // Transaction-level reference model.
    logic [7:0]  shadow [0:MEM_BYTES-1];
    int          cyc = 0;
    int          next_idle, strobe_cyc, rsp_cyc;
    bit          last_b, exp_rd, exp_wr, rsp_port, pend_err, held_err;
    logic [1:0]  m_size;
    logic [63:0] m_addr, m_wdata, pend_rdata, held_rdata;
    bit          granted_a = 1'b0, granted_b = 1'b0;
    int          a_pulses = 0, b_pulses = 0;
    bit          grant_log [$];
    logic [63:0] got_rdata;
    logic        got_err;

    function automatic logic [63:0] shadow_read(input logic [63:0] addr, input logic [1:0] size);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < nbytes(size); i++) v[8*i +: 8] = shadow[int'(addr) + i];
        return v;
    endfunction

    task automatic model_reset();
        next_idle  = cyc;
        last_b     = 1'b1;
        strobe_cyc = -10;
        rsp_cyc    = -10;
        exp_rd     = 1'b0;
        exp_wr     = 1'b0;
        held_rdata = 64'd0;
        held_err   = 1'b0;
    endtask

    // One clock: compare all outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit          idle, ga, gb, w, err;
        logic [1:0]  sz;
        logic [63:0] ad;
        logic [64:0] end_addr;
        @(negedge clk);
        idle = (cyc >= next_idle);
        ga = 1'b0;
        gb = 1'b0;
        if (idle) begin
            if (a_if.req_valid && b_if.req_valid) begin
                ga = last_b;
                gb = !last_b;
            end else if (a_if.req_valid) ga = 1'b1;
            else if (b_if.req_valid) gb = 1'b1;
        end
        if (cyc == rsp_cyc) begin
            held_rdata = pend_rdata;
            held_err   = pend_err;
        end
        chk("a_req_ready", a_if.req_ready, ga);
        chk("b_req_ready", b_if.req_ready, gb);
        chk("busy", busy, !idle);
        chk("mem_read", m_if.read, (cyc == strobe_cyc) && exp_rd);
        chk("mem_write", m_if.write, (cyc == strobe_cyc) && exp_wr);
        chk("a_rsp_valid", a_if.rsp_valid, (cyc == rsp_cyc) && !rsp_port);
        chk("b_rsp_valid", b_if.rsp_valid, (cyc == rsp_cyc) && rsp_port);
        chk("rsp_rdata", rsp_rdata, held_rdata);
        chk("rsp_err", rsp_err, held_err);
        if (cyc == strobe_cyc) begin
            chk("mem_addr", m_if.addr, m_addr);
            chk("mem_size", m_if.size, m_size);
            chk("mem_wdata", m_if.wdata, m_wdata);
        end
        if (a_if.rsp_valid) a_pulses++;
        if (b_if.rsp_valid) b_pulses++;
        if (a_if.rsp_valid || b_if.rsp_valid) begin
            got_rdata = rsp_rdata;
            got_err   = rsp_err;
        end
        @(posedge clk);
        if (cyc == strobe_cyc && exp_wr)
            for (int i = 0; i < nbytes(m_size); i++) shadow[int'(m_addr) + i] = m_wdata[8*i +: 8];
        if (ga || gb) begin
            w        = gb ? b_if.req_write : a_if.req_write;
            sz       = gb ? b_if.req_size  : a_if.req_size;
            ad       = gb ? b_if.req_addr  : a_if.req_addr;
            m_wdata  = gb ? b_if.req_wdata : a_if.req_wdata;
            end_addr = {1'b0, ad} + 65'(nbytes(sz));
            err      = ((ad % 64'(nbytes(sz))) != 64'd0) || (end_addr > 65'(MEM_BYTES));
            m_size     = sz;
            m_addr     = ad;
            exp_rd     = !err && !w;
            exp_wr     = !err && w;
            strobe_cyc = cyc + 1;
            rsp_cyc    = cyc + 3;
            next_idle  = cyc + 3;
            rsp_port   = gb;
            last_b     = gb;
            pend_err   = err;
            pend_rdata = (!w && !err) ? shadow_read(ad, sz) : 64'd0;
            grant_log.push_back(gb);
        end
        granted_a = ga;
        granted_b = gb;
        cyc++;
        #1;
    endtask

    task automatic drive(input bit port, input bit v, input bit w, input logic [1:0] sz,
                         input logic [63:0] ad, input logic [63:0] wd);
        if (port) begin
            b_if.req_valid = v; b_if.req_write = w; b_if.req_size = sz;
            b_if.req_addr  = ad; b_if.req_wdata = wd;
        end else begin
            a_if.req_valid = v; a_if.req_write = w; a_if.req_size = sz;
            a_if.req_addr  = ad; a_if.req_wdata = wd;
        end
    endtask

    // Present one request, wait (bounded) for its grant, then run through its response cycle.
    task automatic issue(input bit port, input bit w, input logic [1:0] sz,
                         input logic [63:0] ad, input logic [63:0] wd);
        int budget;
        budget = 0;
        drive(port, 1'b1, w, sz, ad, wd);
        do begin
            step();
            budget++;
        end while (!(port ? granted_b : granted_a) && budget < 20);
        if (!(port ? granted_b : granted_a)) chk("grant_timeout", 64'd0, 64'd1);
        drive(port, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (3) step();
    endtask

    task automatic do_reset(input bit reload);
        rst = 1'b1;
        load_mem = reload;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_read", m_if.read, 1'b0);
        chk("rst_mem_write", m_if.write, 1'b0);
        chk("rst_mem_addr", m_if.addr, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_a_rsp", a_if.rsp_valid, 1'b0);
        chk("rst_b_rsp", b_if.rsp_valid, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_req(input bit port);
        logic [63:0] ad;
        if ($urandom_range(0, 9) == 0) ad = {$urandom, $urandom};
        else ad = 64'($urandom_range(0, 95));
        drive(port, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ad, {$urandom, $urandom});
    endtask

    initial begin
        logic [63:0] orig;
        rst = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) shadow[i] = init_byte(i);
        do_reset(1'b1);

        // A load double at 8: response three cycles after grant.
        issue(1'b0, 1'b0, 2'b11, 64'd8, 64'd0);
        chk("t1_rdata", got_rdata, 64'h1122334455667788);
        chk("t1_err", got_err, 1'b0);

        // B store byte to 3, then B load word 0.
        issue(1'b1, 1'b1, 2'b10, 64'd3, 64'h00000000000000AB);
        issue(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);
        chk("t2_byte3", got_rdata[31:24], 64'hAB);
        chk("t2_upper", got_rdata[63:32], 64'd0);

        // Both ports held valid for 12 cycles: alternation A,B,A,B.
        grant_log.delete();
        a_pulses = 0;
        b_pulses = 0;
        drive(1'b0, 1'b1, 1'b0, 2'b00, 64'd4, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b01, 64'd6, 64'd0);
        repeat (12) step();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (3) step();
        chk("t3_grants", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", 64'(grant_log[i]), 64'(i % 2));
        end
        chk("t3_a_pulses", 64'(a_pulses), 64'd2);
        chk("t3_b_pulses", 64'(b_pulses), 64'd2);

        // Misaligned and out-of-range accesses.
        issue(1'b0, 1'b0, 2'b00, 64'd2, 64'd0);
        chk("t4_err", got_err, 1'b1);
        chk("t4_rdata", got_rdata, 64'd0);
        issue(1'b0, 1'b1, 2'b11, 64'd84, 64'hFFFF0000FFFF0000);
        chk("t5_range_err", got_err, 1'b1);
        issue(1'b0, 1'b0, 2'b00, 64'hFFFFFFFFFFFFFFFC, 64'd0);
        chk("t5_wrap_err", got_err, 1'b1);
        issue(1'b1, 1'b0, 2'b00, 64'd84, 64'd0);
        chk("t5_last_word_ok", got_err, 1'b0);

        // Reset during ISSUE of a store: strobe drops at once, memory keeps old data.
        orig = 64'd0;
        for (int i = 0; i < 8; i++) orig[8*i +: 8] = init_byte(16 + i);
        drive(1'b0, 1'b1, 1'b1, 2'b11, 64'd16, 64'hDEADBEEFCAFEF00D);
        step();
        chk("t6_granted", granted_a, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        chk("t6_write_issue", m_if.write, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_write_drop", m_if.write, 1'b0);
        chk("t6_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (4) step();
        issue(1'b0, 1'b0, 2'b11, 64'd16, 64'd0);
        chk("t6_readback", got_rdata, orig);

        // Randomized traffic, including withdrawals before grant.
        for (int n = 0; n < 400; n++) begin
            if (granted_a || (a_if.req_valid && $urandom_range(0, 19) == 0)) a_if.req_valid = 1'b0;
            if (granted_b || (b_if.req_valid && $urandom_range(0, 19) == 0)) b_if.req_valid = 1'b0;
            if (!a_if.req_valid && $urandom_range(0, 2) == 0) rand_req(1'b0);
            if (!b_if.req_valid && $urandom_range(0, 2) == 0) rand_req(1'b1);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (4) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
